// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared constants for the registered ripple-carry adder
//
// Purpose:
//   Width constants shared by full_adder and its bit cell.
//
// Contents:
//   FA_DEFAULT_WIDTH  default operand width (1 bit)
//   FA_MAX_WIDTH      widest supported operand (64 bits)
//   fa_width_ok()     true when a width lies in 1..FA_MAX_WIDTH
package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_MAX_WIDTH     = 64;

  function automatic bit fa_width_ok(input int width);
    return (width >= 1) && (width <= FA_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - one-bit combinational full adder
//
// Purpose:
//   One bit position of the ripple-carry chain in full_adder.
//
// Ports:
//   a, b  operand bits
//   cin   carry into this bit
//   s     sum bit      (a ^ b ^ cin)
//   cout  carry out    (majority of a, b, cin)
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - WIDTH-bit ripple-carry adder with one output register stage
//
// Purpose:
//   Computes {carry_out, sum} = a + b + carry_in through a chain of
//   full_adder_cell instances, and registers the result with a 1-cycle latency.
//   A new operation can be accepted every cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears all outputs
//   in_valid   a, b, carry_in are sampled on a rising edge when high
//   a, b       WIDTH-bit operands (unsigned; two's complement for overflow)
//   carry_in   carry into bit 0
//   out_valid  high for the single cycle after each accepted operation
//   sum        registered result bits [WIDTH-1:0]
//   carry_out  registered carry out of the MSB
//   overflow   registered signed overflow (carry into MSB ^ carry out of MSB)
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;
  logic             overflow_comb;

  assign carry[0] = carry_in;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder_cell u_cell (
        .a    (a[i]),
        .b    (b[i]),
        .cin  (carry[i]),
        .s    (sum_comb[i]),
        .cout (carry[i+1])
      );
    end
  endgenerate

  // For WIDTH=1 the carry into the MSB is carry_in itself, so this also
  // covers the single-bit case without special handling.
  assign overflow_comb = carry[WIDTH] ^ carry[WIDTH-1];

  // Result registers only load when in_valid is high, so undriven or X
  // operands outside a valid cycle never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= sum_comb;
        carry_out <= carry[WIDTH];
        overflow  <= overflow_comb;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed and back-to-back checks of full_adder at widths 1, 8 and 16
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // WIDTH=1 instance
  logic       iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0;
  logic       ov1, s1, co1, of1;
  // WIDTH=8 instance
  logic       iv8 = 1'b0, ci8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       ov8, co8, of8;
  // WIDTH=16 instance
  logic        iv16 = 1'b0, ci16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        ov16, co16, of16;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .carry_in(ci1),
    .out_valid(ov1), .sum(s1), .carry_out(co1), .overflow(of1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .carry_in(ci8),
    .out_valid(ov8), .sum(s8), .carry_out(co8), .overflow(of8)
  );

  full_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .a(a16), .b(b16), .carry_in(ci16),
    .out_valid(ov16), .sum(s16), .carry_out(co16), .overflow(of16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv1 = 1'b0; iv8 = 1'b0; iv16 = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({ov1, s1, co1, of1} !== 4'b0) begin
      n_bad++; $display("FAIL reset_w1 got=%b want=0000", {ov1, s1, co1, of1});
    end
    n_cmp++;
    if ({ov8, s8, co8, of8} !== 11'b0) begin
      n_bad++; $display("FAIL reset_w8 got=%h want=000", {ov8, s8, co8, of8});
    end
    n_cmp++;
    if ({ov16, s16, co16, of16} !== 19'b0) begin
      n_bad++; $display("FAIL reset_w16 got=%h want=00000", {ov16, s16, co16, of16});
    end
    rst = 1'b0;
  endtask

  task automatic test_w1_truth_table();
    logic [1:0] exp_cs [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; ci1 = v[0]; iv1 = 1'b1;
      tick();
      n_cmp++;
      if ({co1, s1} !== exp_cs[i] || ov1 !== 1'b1) begin
        n_bad++; $display("FAIL w1_vec%0d got co,s=%b valid=%b want co,s=%b valid=1", i, {co1, s1}, ov1, exp_cs[i]);
      end
      n_cmp++;
      if (of1 !== (v[0] ^ exp_cs[i][1])) begin
        n_bad++; $display("FAIL w1_ovf%0d got=%b want=%b", i, of1, v[0] ^ exp_cs[i][1]);
      end
    end
    iv1 = 1'b0;
    tick();
    n_cmp++;
    if (ov1 !== 1'b0 || {co1, s1} !== 2'b11) begin
      n_bad++; $display("FAIL w1_idle got valid=%b co,s=%b want valid=0 co,s=11", ov1, {co1, s1});
    end
  endtask

  task automatic test_w8_carry_overflow();
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; iv8 = 1'b1;
    tick();
    n_cmp++;
    if (s8 !== 8'h00 || co8 !== 1'b1 || of8 !== 1'b0 || ov8 !== 1'b1) begin
      n_bad++; $display("FAIL w8_ff_plus_1 got s=%h co=%b of=%b v=%b want s=00 co=1 of=0 v=1", s8, co8, of8, ov8);
    end
    a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0; iv8 = 1'b1;
    tick();
    n_cmp++;
    if (s8 !== 8'h80 || co8 !== 1'b0 || of8 !== 1'b1 || ov8 !== 1'b1) begin
      n_bad++; $display("FAIL w8_7f_plus_1 got s=%h co=%b of=%b v=%b want s=80 co=0 of=1 v=1", s8, co8, of8, ov8);
    end
    iv8 = 1'b0;
    tick();
  endtask

  task automatic test_w8_hold();
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1; iv8 = 1'b1;
    tick();
    n_cmp++;
    if (s8 !== 8'h47 || co8 !== 1'b0 || of8 !== 1'b0 || ov8 !== 1'b1) begin
      n_bad++; $display("FAIL w8_hold_load got s=%h co=%b of=%b v=%b want s=47 co=0 of=0 v=1", s8, co8, of8, ov8);
    end
    // Unsampled inputs carry X and a value that would change every output.
    iv8 = 1'b0; a8 = 'x; b8 = 8'hFF; ci8 = 1'bx;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (s8 !== 8'h47 || co8 !== 1'b0 || of8 !== 1'b0 || ov8 !== 1'b0) begin
        n_bad++; $display("FAIL w8_hold_idle%0d got s=%h co=%b of=%b v=%b want s=47 co=0 of=0 v=0", i, s8, co8, of8, ov8);
      end
    end
    a8 = '0; b8 = '0; ci8 = 1'b0;
  endtask

  task automatic test_reset_with_valid();
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; iv8 = 1'b1; rst = 1'b1;
    tick();
    n_cmp++;
    if ({ov8, s8, co8, of8} !== 11'b0) begin
      n_bad++; $display("FAIL rst_discard got v=%b s=%h co=%b of=%b want all 0", ov8, s8, co8, of8);
    end
    rst = 1'b0;
    a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; iv8 = 1'b1;
    tick();
    n_cmp++;
    if (s8 !== 8'h00 || co8 !== 1'b1 || of8 !== 1'b1 || ov8 !== 1'b1) begin
      n_bad++; $display("FAIL rst_first_op got s=%h co=%b of=%b v=%b want s=00 co=1 of=1 v=1", s8, co8, of8, ov8);
    end
    iv8 = 1'b0;
    tick();
    n_cmp++;
    if (ov8 !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid_pulse got v=%b want v=0", ov8);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_full;
    logic        exp_of;
    int          errs;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
      iv16 = 1'b1;
      exp_full = {1'b0, a16} + {1'b0, b16} + {16'b0, ci16};
      exp_of   = (a16[15] == b16[15]) && (exp_full[15] != a16[15]);
      tick();
      n_cmp++;
      if ({co16, s16} !== exp_full || of16 !== exp_of || ov16 !== 1'b1) begin
        n_bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL b2b_%0d got co,s=%h of=%b v=%b want co,s=%h of=%b v=1", i, {co16, s16}, of16, ov16, exp_full, exp_of);
      end
    end
    iv16 = 1'b0;
    tick();
    n_cmp++;
    if (ov16 !== 1'b0) begin
      n_bad++; $display("FAIL b2b_end got v=%b want v=0", ov16);
    end
  endtask

  initial begin
    test_reset();
    test_w1_truth_table();
    test_w8_carry_overflow();
    test_w8_hold();
    test_reset_with_valid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
